// File: rtl/mseq_pkg.sv
// Shared state encoding, period helper and default parameters for the m-sequence scheduler.
package mseq_pkg;

    localparam int MSEQ_DATA_WIDTH_DEF  = 8;
    localparam int MSEQ_TABLE_DEPTH_DEF = 32;
    localparam int MSEQ_RST_CYCLES_DEF  = 2;

    // Fixed encoding so existing register dumps and scripts keep decoding the state field.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        MSEQ_IDLE = ST_IDLE,
        MSEQ_LOAD = ST_LOAD,
        MSEQ_RUN  = ST_RUN,
        MSEQ_NEXT = ST_NEXT,
        MSEQ_DONE = ST_DONE
    } mseq_state_t;

    function automatic int MSEQ_PERIOD(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/mseq_seed_table.sv
// Seed (feedback polynomial) table: one synchronous write port, one asynchronous read port.
module mseq_seed_table
    import mseq_pkg::*;
#(
    parameter int DATA_WIDTH  = MSEQ_DATA_WIDTH_DEF,
    parameter int TABLE_DEPTH = MSEQ_TABLE_DEPTH_DEF
) (
    input  logic                           MSEQ_clk,
    input  logic                           wr_en,
    input  logic [$clog2(TABLE_DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [$clog2(TABLE_DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data
);

    logic [DATA_WIDTH-1:0] mem [TABLE_DEPTH];

    // NOTE: the array has no reset on purpose; contents survive MSEQ_rst_n and a reset
    // port would turn a compact register file into TABLE_DEPTH resettable flops.
    always_ff @(posedge MSEQ_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mseq_scheduler.sv
// Walks the seed table and drives M_sequence one full period per entry.
// Optional build macro: MSEQ_SCHED_LOOP_EN (wrap to entry 0 forever; run ends only on stop).
module mseq_scheduler
    import mseq_pkg::*;
#(
    parameter int DATA_WIDTH  = MSEQ_DATA_WIDTH_DEF,
    parameter int TABLE_DEPTH = MSEQ_TABLE_DEPTH_DEF,
    parameter int RST_CYCLES  = MSEQ_RST_CYCLES_DEF
) (
    input  logic                           MSEQ_clk,
    input  logic                           MSEQ_rst_n,
    input  logic                           cfg_we,
    input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0]          cfg_data,
    input  logic [$clog2(TABLE_DEPTH):0]   num_seeds,
    input  logic [DATA_WIDTH-1:0]          init_base,
    input  logic                           start,
    input  logic                           stop,
    output logic                           gen_rst_n,
    output logic [DATA_WIDTH-1:0]          gen_seed,
    output logic [DATA_WIDTH-1:0]          gen_init_value,
    input  logic                           gen_bit,
    output logic                           bit_out,
    output logic                           bit_valid,
    output logic                           frame_start,
    output logic [$clog2(TABLE_DEPTH)-1:0] seq_idx,
    output logic                           busy,
    output logic                           done
);

    localparam int AW = $clog2(TABLE_DEPTH);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [DATA_WIDTH-1:0] LAST_BIT = DATA_WIDTH'(MSEQ_PERIOD(DATA_WIDTH) - 1);
    localparam logic [RW-1:0]         LAST_RST = RW'(RST_CYCLES - 1);
    localparam logic [AW:0]           DEPTH_W  = (AW + 1)'(TABLE_DEPTH);

    logic [2:0]            state;
    logic [AW-1:0]         idx;
    logic [AW:0]           num_lat;
    logic [DATA_WIDTH-1:0] base_lat;
    logic [RW-1:0]         rst_cnt;
    logic [DATA_WIDTH-1:0] bit_cnt;

    logic [AW:0]           num_sat;
    logic [AW:0]           idx_inc;
    logic                  last_seed;
    logic [AW-1:0]         nxt_idx;
    logic [AW-1:0]         tbl_raddr;
    logic [DATA_WIDTH-1:0] tbl_rdata;
    logic                  tbl_we;

    // All-zero state locks the LFSR up, so a zero initial value is replaced by 1.
    function automatic logic [DATA_WIDTH-1:0] guard_init(input logic [DATA_WIDTH-1:0] base,
                                                         input logic [AW-1:0]         i);
        logic [DATA_WIDTH-1:0] v;
        v = base + DATA_WIDTH'(i);
        return (v == '0) ? DATA_WIDTH'(1) : v;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        num_sat = num_seeds;
        if (num_seeds == '0) begin
            num_sat = (AW + 1)'(1);
        end else if (num_seeds > DEPTH_W) begin
            num_sat = DEPTH_W;
        end
    end

    assign idx_inc   = {1'b0, idx} + (AW + 1)'(1);
    assign last_seed = (idx_inc == num_lat);
    assign nxt_idx   = last_seed ? '0 : idx_inc[AW-1:0];
    // In IDLE the read port looks at entry 0 so the first load is ready on start.
    assign tbl_raddr = (state == ST_IDLE) ? '0 : nxt_idx;
    assign tbl_we    = cfg_we && (state == ST_IDLE);

    mseq_seed_table #(
        .DATA_WIDTH  (DATA_WIDTH),
        .TABLE_DEPTH (TABLE_DEPTH)
    ) u_seed_table (
        .MSEQ_clk (MSEQ_clk),
        .wr_en    (tbl_we),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .rd_addr  (tbl_raddr),
        .rd_data  (tbl_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
        if (!MSEQ_rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            num_lat        <= '0;
            base_lat       <= '0;
            rst_cnt        <= '0;
            bit_cnt        <= '0;
            gen_seed       <= '0;
            gen_init_value <= '0;
            bit_out        <= 1'b0;
            bit_valid      <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state          <= ST_LOAD;
                        idx            <= '0;
                        num_lat        <= num_sat;
                        base_lat       <= init_base;
                        rst_cnt        <= '0;
                        gen_seed       <= tbl_rdata;
                        gen_init_value <= guard_init(init_base, '0);
                    end
                end

                ST_LOAD: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (rst_cnt == LAST_RST) begin
                        state   <= ST_RUN;
                        bit_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_out     <= gen_bit;
                        bit_valid   <= 1'b1;
                        frame_start <= (bit_cnt == '0);
                        bit_cnt     <= bit_cnt + DATA_WIDTH'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_NEXT;
                        end
                    end
                end

                ST_NEXT: begin
                    if (stop) begin
                        state <= ST_IDLE;
`ifdef MSEQ_SCHED_LOOP_EN
                    end else begin
`else
                    end else if (last_seed) begin
                        state <= ST_DONE;
                    end else begin
`endif
                        state          <= ST_LOAD;
                        idx            <= nxt_idx;
                        rst_cnt        <= '0;
                        gen_seed       <= tbl_rdata;
                        gen_init_value <= guard_init(base_lat, nxt_idx);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gen_rst_n = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign seq_idx   = idx;

endmodule

// File: tb/tb_mseq_scheduler.sv
// Randomized self-checking bench for mseq_scheduler with a behavioural M_sequence generator.
module tb_mseq_scheduler;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RSTC  = 2;
    localparam int PER   = 255;

    logic            MSEQ_clk;
    logic            MSEQ_rst_n;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [DW-1:0]   cfg_data;
    logic [AW:0]     num_seeds;
    logic [DW-1:0]   init_base;
    logic            start;
    logic            stop;
    logic            gen_rst_n;
    logic [DW-1:0]   gen_seed;
    logic [DW-1:0]   gen_init_value;
    logic            gen_bit;
    logic            bit_out;
    logic            bit_valid;
    logic            frame_start;
    logic [AW-1:0]   seq_idx;
    logic            busy;
    logic            done;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] shadow [DEPTH];
    logic [255:0]  run_a_cap;
    logic [255:0]  cap_tmp;

    mseq_scheduler #(
        .DATA_WIDTH  (DW),
        .TABLE_DEPTH (DEPTH),
        .RST_CYCLES  (RSTC)
    ) dut (
        .MSEQ_clk       (MSEQ_clk),
        .MSEQ_rst_n     (MSEQ_rst_n),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .num_seeds      (num_seeds),
        .init_base      (init_base),
        .start          (start),
        .stop           (stop),
        .gen_rst_n      (gen_rst_n),
        .gen_seed       (gen_seed),
        .gen_init_value (gen_init_value),
        .gen_bit        (gen_bit),
        .bit_out        (bit_out),
        .bit_valid      (bit_valid),
        .frame_start    (frame_start),
        .seq_idx        (seq_idx),
        .busy           (busy),
        .done           (done)
    );

    initial MSEQ_clk = 1'b0;
    always #5 MSEQ_clk = ~MSEQ_clk;

    // Behavioural M_sequence: Galois LFSR, loads init while held in reset, output is bit 0.
    logic [DW-1:0] lfsr;
    always @(posedge MSEQ_clk) begin
        if (!gen_rst_n) lfsr <= gen_init_value;
        else            lfsr <= {1'b0, lfsr[DW-1:1]} ^ (lfsr[0] ? gen_seed : '0);
    end
    assign gen_bit = lfsr[0];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_init(input logic [DW-1:0] base, input int i);
        int v;
        v = (int'(base) + i) % 256;
        if (v == 0) v = 1;
        return DW'(v);
    endfunction

    // Expected period: bit k is bit 0 of the state after k LFSR steps.
    function automatic logic [255:0] ref_frame(input logic [DW-1:0] seed, input logic [DW-1:0] init);
        logic [DW-1:0] s;
        logic [255:0]  r;
        s = init;
        r = '0;
        for (int k = 0; k < PER; k++) begin
            r[k] = s[0];
            s = (s >> 1) ^ (s[0] ? seed : 8'h00);
        end
        return r;
    endfunction

    task automatic check_reset_outputs(input string where);
        check({where, "_gen_rst_n"},      256'(gen_rst_n),      256'(0));
        check({where, "_gen_seed"},       256'(gen_seed),       256'(0));
        check({where, "_gen_init_value"}, 256'(gen_init_value), 256'(0));
        check({where, "_bit_out"},        256'(bit_out),        256'(0));
        check({where, "_bit_valid"},      256'(bit_valid),      256'(0));
        check({where, "_frame_start"},    256'(frame_start),    256'(0));
        check({where, "_seq_idx"},        256'(seq_idx),        256'(0));
        check({where, "_busy"},           256'(busy),           256'(0));
        check({where, "_done"},           256'(done),           256'(0));
    endtask

    // One run from IDLE; called at a negedge. stop_bit >= 0 aborts frame 0 at that bit.
    task automatic do_run(input int n_port, input logic [DW-1:0] base, input int stop_bit,
                          input bit poke, output logic [255:0] cap0);
        int           eff;
        int           cyc;
        int           gap;
        int           lo;
        bit           seen;
        bit           valid_ok;
        bit           saw_bad;
        logic [255:0] cap;
        eff  = (n_port == 0) ? 1 : ((n_port > DEPTH) ? DEPTH : n_port);
        cap0 = '0;
        num_seeds = (AW + 1)'(n_port);
        init_base = base;
        start = 1'b1;
        @(negedge MSEQ_clk);
        start = 1'b0;
        cyc = 1;
        gap = 0;
        check("busy_after_start", 256'(busy), 256'(1));
        for (int f = 0; f < eff; f++) begin
            seen = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                if (frame_start) seen = 1'b1;
                else begin @(negedge MSEQ_clk); cyc++; gap++; end
            end
            check("frame_start_seen", 256'(seen), 256'(1));
            if (!seen) return;
            if (f > 0) check("seed_gap", 256'(gap), 256'(RSTC + 2));
            check("seq_idx", 256'(seq_idx), 256'(f));
            check("gen_seed", 256'(gen_seed), 256'(shadow[f]));
            check("gen_init_value", 256'(gen_init_value), 256'(exp_init(base, f)));
            cap = '0;
            valid_ok = 1'b1;
            for (int k = 0; k < PER; k++) begin
                if (!bit_valid) valid_ok = 1'b0;
                cap[k] = bit_out;
                if (f == 0 && k == stop_bit) begin
                    stop = 1'b1;
                    @(negedge MSEQ_clk);
                    stop = 1'b0;
                    check("stop_bit_valid", 256'(bit_valid), 256'(0));
                    check("stop_gen_rst_n", 256'(gen_rst_n), 256'(0));
                    check("stop_busy", 256'(busy), 256'(0));
                    saw_bad = 1'b0;
                    for (int w = 0; w < 300; w++) begin
                        if (done || bit_valid || busy) saw_bad = 1'b1;
                        @(negedge MSEQ_clk);
                    end
                    check("stop_no_done", 256'(saw_bad), 256'(0));
                    return;
                end
                if (poke && f == 0 && k == 10) begin
                    cfg_we    = 1'b1;
                    cfg_addr  = AW'(eff - 1);
                    cfg_data  = ~shadow[eff - 1];
                    start     = 1'b1;
                    num_seeds = '0;
                end else if (poke && f == 0 && k == 11) begin
                    cfg_we = 1'b0;
                    start  = 1'b0;
                end
                @(negedge MSEQ_clk);
                cyc++;
            end
            gap = 1;
            check("bit_valid_held", 256'(valid_ok), 256'(1));
            check("bit_valid_drop", 256'(bit_valid), 256'(0));
            check("frame_bits", cap, ref_frame(shadow[f], exp_init(base, f)));
            if (f == 0) cap0 = cap;
        end
        for (int w = 0; w < 5 && !done; w++) begin
            @(negedge MSEQ_clk);
            cyc++;
        end
        check("done_pulse", 256'(done), 256'(1));
        lo = eff * (RSTC + PER + 1);
        check("run_length", 256'(cyc >= lo && cyc <= lo + 3), 256'(1));
        @(negedge MSEQ_clk);
        check("done_single", 256'(done), 256'(0));
        check("busy_after_done", 256'(busy), 256'(0));
    endtask

    initial begin
        bit seen;
        bit saw_done;
        MSEQ_rst_n = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        num_seeds  = '0;
        init_base  = '0;
        start      = 1'b0;
        stop       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            shadow[i] = (i == 0) ? 8'd113 : (i == 1) ? 8'd169 : DW'($urandom_range(1, 255));
        end
        repeat (3) @(negedge MSEQ_clk);
        check_reset_outputs("reset");
        MSEQ_rst_n = 1'b1;
        @(negedge MSEQ_clk);

        for (int i = 0; i < DEPTH; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = AW'(i);
            cfg_data = shadow[i];
            @(negedge MSEQ_clk);
        end
        cfg_we = 1'b0;

        start = 1'b1;
        stop  = 1'b1;
        @(negedge MSEQ_clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", 256'(busy), 256'(0));

`ifdef MSEQ_SCHED_LOOP_EN
        num_seeds = (AW + 1)'(3);
        init_base = 8'd54;
        start = 1'b1;
        @(negedge MSEQ_clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int f = 0; f < 5; f++) begin
            seen = 1'b0;
            for (int w = 0; w < 400 && !seen; w++) begin
                if (frame_start) seen = 1'b1;
                else begin
                    if (done) saw_done = 1'b1;
                    @(negedge MSEQ_clk);
                end
            end
            check("loop_frame_seen", 256'(seen), 256'(1));
            check("loop_seq_idx", 256'(seq_idx), 256'(f % 3));
            check("loop_init", 256'(gen_init_value), 256'(exp_init(8'd54, f % 3)));
            @(negedge MSEQ_clk);
        end
        check("loop_no_done", 256'(saw_done), 256'(0));
        check("loop_busy", 256'(busy), 256'(1));
        stop = 1'b1;
        @(negedge MSEQ_clk);
        stop = 1'b0;
        check("loop_stop_busy", 256'(busy), 256'(0));
        check("loop_stop_valid", 256'(bit_valid), 256'(0));
`else
        do_run(2, 8'd54, -1, 1'b0, run_a_cap);
        do_run(2, 8'd54, -1, 1'b0, cap_tmp);
        check("repeat_frame0", cap_tmp, run_a_cap);
        do_run(2, 8'd255, -1, 1'b0, cap_tmp);
        do_run(2, 8'd54, 100, 1'b0, cap_tmp);

        num_seeds = (AW + 1)'(2);
        init_base = 8'd54;
        start = 1'b1;
        @(negedge MSEQ_clk);
        start = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            if (frame_start) seen = 1'b1;
            else @(negedge MSEQ_clk);
        end
        check("midrst_frame_seen", 256'(seen), 256'(1));
        repeat (50) @(negedge MSEQ_clk);
        MSEQ_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge MSEQ_clk);
        MSEQ_rst_n = 1'b1;
        @(negedge MSEQ_clk);
        do_run(2, 8'd54, -1, 1'b0, cap_tmp);
        check("table_retained", cap_tmp, run_a_cap);

        do_run(0, DW'($urandom), -1, 1'b1, cap_tmp);
        do_run(int'($urandom_range(3, 6)), DW'($urandom), -1, 1'b1, cap_tmp);
        do_run(40, DW'($urandom), -1, 1'b1, cap_tmp);
        saw_done = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mseq_scheduler.md
# mseq_scheduler

Sequencing controller for the `M_sequence` LFSR generator. Holds a programmable table of feedback polynomials (seeds). On `start` it walks the table: for each entry it resets the generator, loads seed and initial value, and streams exactly one full m-sequence period (2^DATA_WIDTH−1 bits) to downstream logic with valid/index tagging. It sits between the register/config interface and the `M_sequence` instance it drives.

## Interface
Parameters:
- `DATA_WIDTH`, 8: LFSR width; must match the generator.
- `TABLE_DEPTH`, 32: number of seed table entries (power of two).
- `RST_CYCLES`, 2: cycles `gen_rst_n` is held low per load (≥1).

Ports:
- `MSEQ_clk` in 1: clock.
- `MSEQ_rst_n` in 1: reset, asynchronous, active-low.
- `cfg_we` in 1: seed table write strobe.
- `cfg_addr` in log2(TABLE_DEPTH): table write address.
- `cfg_data` in DATA_WIDTH: seed to write.
- `num_seeds` in log2(TABLE_DEPTH)+1: entries to run, 1..TABLE_DEPTH; sampled on `start`.
- `init_base` in DATA_WIDTH: base initial value; sampled on `start`.
- `start` in 1: single-cycle pulse; begin run.
- `stop` in 1: abort run.
- `gen_rst_n` out 1: drives generator `MSEQ_rst_n`.
- `gen_seed` out DATA_WIDTH: drives generator `MSEQ_seed`.
- `gen_init_value` out DATA_WIDTH: drives generator `MSEQ_init_value`.
- `gen_bit` in 1: generator `MSEQ_output`.
- `bit_out` out 1: registered copy of `gen_bit`.
- `bit_valid` out 1: `bit_out` belongs to a period.
- `frame_start` out 1: high with first valid bit of each period.
- `seq_idx` out log2(TABLE_DEPTH): table index of current period.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at run completion.

## Operation
- States: IDLE, LOAD, RUN, NEXT, DONE.
- IDLE: `gen_rst_n`=0; `start` → LOAD with idx=0, latch `num_seeds`, `init_base`.
- LOAD: `gen_seed`=table[idx], `gen_init_value`=init_base+idx (mod 2^DATA_WIDTH; if result 0, drive 1 — all-zero lock-up guard); `gen_rst_n`=0 for RST_CYCLES cycles → RUN.
- RUN: `gen_rst_n`=1; bit counter counts 2^DATA_WIDTH−1 valid bits; on last bit → NEXT.
- NEXT: if idx+1 == num_seeds → DONE, else idx++ → LOAD.
- DONE: `done`=1 one cycle → IDLE.
- `stop` in any non-IDLE state → IDLE next cycle; `gen_rst_n`=0, `bit_valid`=0, no `done`.
- `start` while busy: ignored. `start` and `stop` same cycle in IDLE: stop wins (stay IDLE).
- `num_seeds`=0 treated as 1; values > TABLE_DEPTH saturate to TABLE_DEPTH.
- `cfg_we` while busy: ignored; writes only take effect in IDLE.
- Table contents not cleared by reset; unwritten entries are X in sim, don't-care.

## Timing
- Reset values: `gen_rst_n`=0, `gen_seed`=0, `gen_init_value`=0, `bit_out`=0, `bit_valid`=0, `frame_start`=0, `seq_idx`=0, `busy`=0, `done`=0.
- `busy` high from cycle after `start` until DONE state exits.
- `gen_bit` sampled in RUN; `bit_out`/`bit_valid` one cycle later.
- Per-seed gap between last valid bit and next `frame_start`: RST_CYCLES+2 cycles.
- Run length (num_seeds=N): N·(RST_CYCLES+(2^DATA_WIDTH−1)+1)+O(3) cycles.

## Configuration
- `MSEQ_SCHED_LOOP_EN` defined: NEXT after last entry wraps idx to 0 and continues to LOAD; run ends only via `stop`; `done` never asserts.
- Not defined: run terminates in DONE as above.

## Structure
- Package `mseq_pkg`: state enum `mseq_state_t`, `MSEQ_PERIOD(w)` constant function (2^w−1), default parameter constants.
- Sub-module `mseq_seed_table`: TABLE_DEPTH×DATA_WIDTH register array, one write port, one async read port.

## Test plan
- Table {113,169}, num_seeds=2, init_base=54, start → two frames of 255 valid bits, `seq_idx` 0 then 1, `gen_init_value` 54 then 55, single `done`.
- Each frame vs. reference LFSR model → bit-exact; frame repeats identically on second run.
- init_base=255, num_seeds=2 → second load drives `gen_init_value`=1 (zero guard).
- `stop` at bit 100 of frame 0 → `bit_valid` low next cycle, `gen_rst_n`=0, no `done`, `busy`=0.
- `MSEQ_rst_n` asserted mid-RUN → all outputs at reset values immediately; table contents retained.
- `MSEQ_SCHED_LOOP_EN`, num_seeds=3 → `seq_idx` 0,1,2,0,1 with no `done`.
